// File: rtl/prim_skid_reg.sv
// prim_skid_reg
//   Registered valid/ready slice with a two-entry skid store. Both the forward
//   (valid/data) and the backward (ready) paths are cut by flops, so it can sit
//   on interfaces that carry backpressure. No data transformation, one clock.
//
// Ports
//   clk_i        clock, all state changes on rising edge
//   rst_i        synchronous active-high reset (wins over flush_i)
//   flush_i      synchronous clear of all stored beats
//   valid_i      upstream beat present
//   ready_o      slice can accept a beat
//   data_i       upstream beat
//   valid_o      downstream beat present
//   ready_i      downstream accepts the beat
//   data_o       downstream beat (main register)
//   occupancy_o  stored beats, 0..2 (equals the state encoding)
module prim_skid_reg #(
    parameter int unsigned       Width      = 32,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    if (Width == 0) begin : g_bad_width
        $error("prim_skid_reg: Width must be at least 1");
    end

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             acc;
    logic             pop;

    // Handshake outputs decode from the state register only; rst_i is the one
    // combinational term so nothing is taken while reset is held.
    assign ready_o     = (state_q != StFull) && !rst_i;
    assign valid_o     = (state_q != StEmpty);
    assign data_o      = main_q;
    assign occupancy_o = state_q;

    assign acc = valid_i && ready_o;
    assign pop = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            main_q  <= ResetValue;
            skid_q  <= ResetValue;
        end else if (flush_i) begin
            // A pop this cycle already completed downstream; an accept is dropped.
            state_q <= StEmpty;
            main_q  <= ResetValue;
            skid_q  <= ResetValue;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        main_q  <= data_i;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (acc && pop) begin
                        main_q <= data_i;
                    end else if (acc) begin
                        // Consumer stalled: park the new beat behind main.
                        skid_q  <= data_i;
                        state_q <= StFull;
                    end else if (pop) begin
                        // main keeps its stale value; it is not observed while empty.
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        main_q  <= skid_q;
                        state_q <= StBusy;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (occupancy_o != 2'd3);
        end
    end

endmodule
